// File: rtl/voice_allocator.sv
// Four-voice note allocator for a polyphonic synth.
// Maps note-on/note-off commands onto four oscillator voices, keeps an age
// ranking for voice stealing, forces a short gate gap when an already
// sounding voice is retriggered or stolen, and times each voice's release
// tail in sample ticks before returning it to the idle pool.
module voice_allocator #(
    parameter int FREQ_W        = 32,
    parameter int ID_W          = 7,
    parameter int RELEASE_TICKS = 4800,
    parameter int GAP_CYCLES    = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              tick,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_on,
    input  logic [ID_W-1:0]   cmd_id,
    input  logic [FREQ_W-1:0] cmd_freq,
    output logic [FREQ_W-1:0] freq_1,
    output logic [FREQ_W-1:0] freq_2,
    output logic [FREQ_W-1:0] freq_3,
    output logic [FREQ_W-1:0] freq_4,
    output logic [3:0]        gate,
    output logic [3:0]        voice_busy
);

    localparam int RT_W = $clog2(RELEASE_TICKS + 1);

    typedef enum logic [1:0] {
        V_IDLE    = 2'd0,
        V_ACTIVE  = 2'd1,
        V_RELEASE = 2'd2
    } vstate_t;

    typedef enum logic {
        G_READY = 1'b0,
        G_GAP   = 1'b1
    } gstate_t;

    // Per-voice state
    vstate_t           vstate_r  [4];
    logic [ID_W-1:0]   id_r      [4];
    logic [FREQ_W-1:0] freq_r    [4];
    logic [1:0]        rank_r    [4];
    logic [RT_W-1:0]   rel_cnt_r [4];
    logic [3:0]        gate_r;
    logic [3:0]        busy_r;

    // Gap sequencer state
    gstate_t           gap_state_r;
    logic [3:0]        gap_cnt_r;
    logic [1:0]        gap_voice_r;
    logic              ready_r;

    // Target selection
    logic [3:0]        on_match_s;
    logic [3:0]        off_match_s;
    logic              hit_found_s;
    logic [1:0]        hit_tgt_s;
    logic              idle_found_s;
    logic [1:0]        idle_tgt_s;
    logic              rel_found_s;
    logic [1:0]        rel_tgt_s;
    logic [1:0]        rel_rank_s;
    logic              act_found_s;
    logic [1:0]        act_tgt_s;
    logic [1:0]        act_rank_s;
    logic [1:0]        tgt_s;
    logic              tgt_active_s;
    logic              xfer_s;

    // Pick the note-on target by priority: id hit, lowest idle, oldest release, oldest active.
    always_comb begin
        on_match_s   = 4'b0000;
        off_match_s  = 4'b0000;
        hit_found_s  = 1'b0;
        hit_tgt_s    = 2'd0;
        idle_found_s = 1'b0;
        idle_tgt_s   = 2'd0;
        rel_found_s  = 1'b0;
        rel_tgt_s    = 2'd0;
        rel_rank_s   = 2'd0;
        act_found_s  = 1'b0;
        act_tgt_s    = 2'd0;
        act_rank_s   = 2'd0;
        // Descending scan so the lowest index overwrites and wins ties.
        for (int i = 3; i >= 0; i--) begin
            if (vstate_r[i] != V_IDLE && id_r[i] == cmd_id) begin
                on_match_s[i] = 1'b1;
                hit_found_s   = 1'b1;
                hit_tgt_s     = 2'(i);
            end else begin
                on_match_s[i] = 1'b0;
            end
            if (vstate_r[i] == V_ACTIVE && id_r[i] == cmd_id) begin
                off_match_s[i] = 1'b1;
            end else begin
                off_match_s[i] = 1'b0;
            end
            if (vstate_r[i] == V_IDLE) begin
                idle_found_s = 1'b1;
                idle_tgt_s   = 2'(i);
            end else begin
                idle_found_s = idle_found_s;
            end
            // Ranks are a permutation, so the highest-rank pick is unique.
            if (vstate_r[i] == V_RELEASE && (!rel_found_s || rank_r[i] > rel_rank_s)) begin
                rel_found_s = 1'b1;
                rel_tgt_s   = 2'(i);
                rel_rank_s  = rank_r[i];
            end else begin
                rel_found_s = rel_found_s;
            end
            if (vstate_r[i] == V_ACTIVE && (!act_found_s || rank_r[i] > act_rank_s)) begin
                act_found_s = 1'b1;
                act_tgt_s   = 2'(i);
                act_rank_s  = rank_r[i];
            end else begin
                act_found_s = act_found_s;
            end
        end
        if (hit_found_s) begin
            tgt_s = hit_tgt_s;
        end else if (idle_found_s) begin
            tgt_s = idle_tgt_s;
        end else if (rel_found_s) begin
            tgt_s = rel_tgt_s;
        end else begin
            tgt_s = act_tgt_s;
        end
        tgt_active_s = (vstate_r[tgt_s] == V_ACTIVE);
        xfer_s       = cmd_valid && ready_r;
    end

    // Gap sequencer plus per-voice state, rank and release-timer updates.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++) begin
                vstate_r[i]  <= V_IDLE;
                id_r[i]      <= '0;
                freq_r[i]    <= '0;
                rank_r[i]    <= 2'(i);
                rel_cnt_r[i] <= '0;
            end
            gate_r      <= 4'b0000;
            busy_r      <= 4'b0000;
            ready_r     <= 1'b0;
            gap_state_r <= G_READY;
            gap_cnt_r   <= 4'd0;
            gap_voice_r <= 2'd0;
        end else begin
            case (gap_state_r)
                G_READY: begin
                    if (xfer_s && cmd_on && tgt_active_s) begin
                        gap_state_r <= G_GAP;
                        gap_cnt_r   <= 4'(GAP_CYCLES);
                        gap_voice_r <= tgt_s;
                        ready_r     <= 1'b0;
                    end else begin
                        ready_r     <= 1'b1;
                    end
                end
                G_GAP: begin
                    // Last gap cycle: reopen the handshake and raise the held gate together.
                    if (gap_cnt_r == 4'd1) begin
                        gap_state_r         <= G_READY;
                        gap_cnt_r           <= 4'd0;
                        ready_r             <= 1'b1;
                        gate_r[gap_voice_r] <= 1'b1;
                    end else begin
                        gap_cnt_r           <= gap_cnt_r - 4'd1;
                    end
                end
                default: begin
                    gap_state_r <= G_READY;
                    gap_cnt_r   <= 4'd0;
                    ready_r     <= 1'b1;
                end
            endcase

            for (int i = 0; i < 4; i++) begin
                if (xfer_s && cmd_on && tgt_s == 2'(i)) begin
                    vstate_r[i]  <= V_ACTIVE;
                    id_r[i]      <= cmd_id;
                    freq_r[i]    <= cmd_freq;
                    rel_cnt_r[i] <= '0;
                    busy_r[i]    <= 1'b1;
                    // A sounding voice gets its gate dropped; the sequencer raises it later.
                    gate_r[i]    <= !tgt_active_s;
                end else if (xfer_s && !cmd_on && off_match_s[i]) begin
                    vstate_r[i]  <= V_RELEASE;
                    rel_cnt_r[i] <= RT_W'(RELEASE_TICKS);
                    gate_r[i]    <= 1'b0;
                end else if (tick && vstate_r[i] == V_RELEASE) begin
                    if (rel_cnt_r[i] == RT_W'(1)) begin
                        vstate_r[i]  <= V_IDLE;
                        rel_cnt_r[i] <= '0;
                        busy_r[i]    <= 1'b0;
                    end else begin
                        rel_cnt_r[i] <= rel_cnt_r[i] - RT_W'(1);
                    end
                end
                if (xfer_s && cmd_on) begin
                    if (tgt_s == 2'(i)) begin
                        rank_r[i] <= 2'd0;
                    end else if (rank_r[i] < rank_r[tgt_s]) begin
                        rank_r[i] <= rank_r[i] + 2'd1;
                    end
                end
            end
        end
    end

    assign freq_1     = freq_r[0];
    assign freq_2     = freq_r[1];
    assign freq_3     = freq_r[2];
    assign freq_4     = freq_r[3];
    assign gate       = gate_r;
    assign voice_busy = busy_r;
    assign cmd_ready  = ready_r;

endmodule
